fsm_seq_ctrl: RTL and testbench

- Control sequencer for the FSM processor datapath.
- Owns the 3-bit processor state register and the 4-bit per-state step counter.
- Issues fetch/execute/write memory requests using a req/ack handshake.
- Emits one-cycle load/increment strobes to the PC, IR and accumulator.
- Sits between the instruction/data memory port and the datapath. The datapath supplies the decoded opcode and the compare flag.

---
 rtl/fsm_seq_ctrl_if.sv | 22 ++
 rtl/fsm_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fsm_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_seq_ctrl_if.sv
// Memory port of the sequencer: level request with write qualifier, one-cycle
// acknowledge from the memory side.

interface fsm_seq_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    // Sequencer side: issues requests, receives acknowledge.
    modport master (
        output mem_req,
        output mem_we,
        input  mem_ack
    );

    // Memory side: observes requests, returns acknowledge.
    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ack
    );
endinterface

// File: rtl/fsm_seq_ctrl.sv
// Control sequencer for the FSM processor datapath.
//
//   state  | code | meaning
//   -------+------+--------------------------------------------------
//   IDLE   |  0   | after reset, waits for start
//   FETCH  |  1   | instruction read request, waits for mem_ack
//   DECODE |  2   | one cycle, opcode from IR is latched and dispatched
//   EXEC   |  3   | operand read for LOAD/ADD, waits for mem_ack
//   WRITE  |  4   | accumulator store for STORE, waits for mem_ack
//   HALT   |  5   | stopped by stop request or memory timeout
//   6, 7   |  -   | illegal, recover to IDLE on the next cycle
//
// Memory-state waits are bounded by TIMEOUT (1..15); an expired wait halts
// the processor and sets the sticky err flag until the next start.

module fsm_seq_ctrl #(
    parameter int unsigned TIMEOUT = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            opcode,
    input  logic                  cmp,
    fsm_seq_ctrl_if.master        mem,
    output logic                  ir_load,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic                  acc_load,
    output logic                  alu_add,
    output logic                  busy,
    output logic                  err,
    output logic [2:0]            state,
    output logic [3:0]            count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_JMPC  = 2'b10;

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);
    localparam logic [3:0] COUNT_MAX   = 4'hF;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [3:0] count_q;
    logic       err_q;
    logic       err_d;
    logic       stop_pend_q;
    logic [1:0] opc_q;

    logic       timed_out;
    logic       running;
    logic       state_change;
    logic [2:0] boundary_state;

    assign timed_out    = (count_q == TIMEOUT_CNT);
    assign running      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign state_change = (state_d != state_q);

    // A stop seen in the boundary cycle itself halts just like a pending one.
    assign boundary_state = (stop_pend_q || stop) ? S_HALT : S_FETCH;

    // Next-state, error flag and one-cycle datapath strobes.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        acc_load = 1'b0;
        alu_add  = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    err_d   = 1'b0;
                end
            end

            S_FETCH: begin
                // An ack arriving on the timeout cycle still completes.
                if (mem.mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_ADD: state_d = S_EXEC;
                    OP_JMPC: begin
                        pc_load = cmp;
                        state_d = boundary_state;
                    end
                    default: state_d = S_WRITE;
                endcase
            end

            S_EXEC: begin
                // alu_add follows the opcode captured in DECODE, not the live IR.
                if (mem.mem_ack) begin
                    acc_load = 1'b1;
                    alu_add  = (opc_q == OP_ADD);
                    state_d  = boundary_state;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end

            S_WRITE: begin
                if (mem.mem_ack) begin
                    state_d = boundary_state;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Keep the datapath untouched while the sequencer is being reset.
        if (rst) begin
            ir_load  = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
            acc_load = 1'b0;
            alu_add  = 1'b0;
        end
    end

    // State register and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Per-state step counter: restarts on every transition, saturates at 15.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
        end else if (state_change) begin
            count_q <= 4'd0;
        end else if (count_q != COUNT_MAX) begin
            count_q <= count_q + 4'd1;
        end
    end

    // Pending stop request, consumed when the processor reaches IDLE or HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            stop_pend_q <= 1'b0;
        end else if ((state_d == S_HALT) || (state_d == S_IDLE)) begin
            stop_pend_q <= 1'b0;
        end else if (stop && running) begin
            stop_pend_q <= 1'b1;
        end
    end

    // Opcode capture for use in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            opc_q <= OP_LOAD;
        end else if (state_q == S_DECODE) begin
            opc_q <= opcode;
        end
    end

    assign mem.mem_req = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WRITE);
    assign mem.mem_we  = (state_q == S_WRITE);
    assign busy        = running;
    assign err         = err_q;
    assign state       = state_q;
    assign count       = count_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed testbench for fsm_seq_ctrl with hand-computed expected values.
// Inputs change 1 ns after the rising edge; outputs are checked before the
// next rising edge.

module tb_fsm_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] opcode;
    logic       cmp;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_load;
    logic       alu_add;
    logic       busy;
    logic       err;
    logic [2:0] state;
    logic [3:0] count;

    int vectors = 0;
    int miscmp  = 0;

    fsm_seq_ctrl_if mif ();

    fsm_seq_ctrl #(.TIMEOUT(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .opcode   (opcode),
        .cmp      (cmp),
        .mem      (mif),
        .ir_load  (ir_load),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .acc_load (acc_load),
        .alu_add  (alu_add),
        .busy     (busy),
        .err      (err),
        .state    (state),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {state, count, mem_req, mem_we, busy, err}
    logic [10:0] obs;
    assign obs = {state, count, mif.mem_req, mif.mem_we, busy, err};

    // {ir_load, pc_inc, pc_load, acc_load, alu_add}
    logic [4:0] strb;
    assign strb = {ir_load, pc_inc, pc_load, acc_load, alu_add};

    // flags = {mem_req, mem_we, busy, err}
    function automatic logic [10:0] mk(input logic [2:0] st, input logic [3:0] cnt,
                                       input logic [3:0] flags);
        return {st, cnt, flags};
    endfunction

    // Zero-wait mixed program: ADD, STORE, JMPC(taken), LOAD, then halt.
    logic [2:0] b2b_st [0:10] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd4,
                                  3'd1, 3'd2, 3'd1, 3'd2, 3'd3};
    logic [4:0] b2b_sb [0:10] = '{5'b11000, 5'b00000, 5'b00011, 5'b11000, 5'b00000, 5'b00000,
                                  5'b11000, 5'b00100, 5'b11000, 5'b00000, 5'b00010};
    logic [1:0] b2b_op [0:10] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00,
                                  2'b00, 2'b10, 2'b00, 2'b00, 2'b00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        rst = 1'b1; start = 1'b0; stop = 1'b0; opcode = 2'b00; cmp = 1'b0;
        mif.mem_ack = 1'b0;
        tick();
        tick();
        e = mk(3'd0, 4'd0, 4'b0000);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL reset_regs obs=%h exp=%h", obs, e); end
        vectors++; if (strb !== 5'b00000) begin miscmp++; $display("FAIL reset_strb strb=%b exp=00000", strb); end
        rst = 1'b0;
        repeat (20) tick();
        e = mk(3'd0, 4'd15, 4'b0000);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL idle_count_sat obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_load_loop();
        logic [10:0] e;
        start = 1'b1; opcode = 2'b00; mif.mem_ack = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = mk(3'd1, 4'd0, 4'b1010);
            vectors++; if (obs !== e) begin miscmp++; $display("FAIL load_fetch obs=%h exp=%h", obs, e); end
            vectors++; if (strb !== 5'b11000) begin miscmp++; $display("FAIL load_fetch_strb strb=%b exp=11000", strb); end
            tick();
            e = mk(3'd2, 4'd0, 4'b0010);
            vectors++; if (obs !== e) begin miscmp++; $display("FAIL load_decode obs=%h exp=%h", obs, e); end
            vectors++; if (strb !== 5'b00000) begin miscmp++; $display("FAIL load_decode_strb strb=%b exp=00000", strb); end
            tick();
            e = mk(3'd3, 4'd0, 4'b1010);
            vectors++; if (obs !== e) begin miscmp++; $display("FAIL load_exec obs=%h exp=%h", obs, e); end
            vectors++; if (strb !== 5'b00010) begin miscmp++; $display("FAIL load_exec_strb strb=%b exp=00010", strb); end
            if (i == 1) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        e = mk(3'd5, 4'd0, 4'b0000);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL load_halt obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_jmpc();
        logic [10:0] e;
        start = 1'b1; opcode = 2'b10; cmp = 1'b1; mif.mem_ack = 1'b1;
        tick();
        start = 1'b0;
        e = mk(3'd1, 4'd0, 4'b1010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL jmpc_fetch1 obs=%h exp=%h", obs, e); end
        tick();
        e = mk(3'd2, 4'd0, 4'b0010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL jmpc_decode1 obs=%h exp=%h", obs, e); end
        vectors++; if (strb !== 5'b00100) begin miscmp++; $display("FAIL jmpc_taken strb=%b exp=00100", strb); end
        cmp = 1'b0;
        tick();
        e = mk(3'd1, 4'd0, 4'b1010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL jmpc_fetch2 obs=%h exp=%h", obs, e); end
        tick();
        e = mk(3'd2, 4'd0, 4'b0010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL jmpc_decode2 obs=%h exp=%h", obs, e); end
        vectors++; if (strb !== 5'b00000) begin miscmp++; $display("FAIL jmpc_not_taken strb=%b exp=00000", strb); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        e = mk(3'd5, 4'd0, 4'b0000);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL jmpc_halt obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_store_wait();
        logic [10:0] e;
        start = 1'b1; opcode = 2'b11; mif.mem_ack = 1'b1;
        tick();
        start = 1'b0;
        tick();
        e = mk(3'd2, 4'd0, 4'b0010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL store_decode obs=%h exp=%h", obs, e); end
        mif.mem_ack = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            e = mk(3'd4, 4'(i), 4'b1110);
            vectors++; if (obs !== e) begin miscmp++; $display("FAIL store_wait%0d obs=%h exp=%h", i, obs, e); end
            if (i == 3) mif.mem_ack = 1'b1;
            tick();
        end
        e = mk(3'd1, 4'd0, 4'b1010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL store_refetch obs=%h exp=%h", obs, e); end
        // Stop raised mid-instruction must take effect at the next boundary.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        e = mk(3'd2, 4'd0, 4'b0010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL stoppend_decode obs=%h exp=%h", obs, e); end
        tick();
        e = mk(3'd4, 4'd0, 4'b1110);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL stoppend_write obs=%h exp=%h", obs, e); end
        tick();
        e = mk(3'd5, 4'd0, 4'b0000);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL stoppend_halt obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_timeout();
        logic [10:0] e;
        start = 1'b1; opcode = 2'b00; mif.mem_ack = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            e = mk(3'd1, 4'(i), 4'b1010);
            vectors++; if (obs !== e) begin miscmp++; $display("FAIL timeout_wait%0d obs=%h exp=%h", i, obs, e); end
            tick();
        end
        e = mk(3'd5, 4'd0, 4'b0001);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL timeout_halt obs=%h exp=%h", obs, e); end
        start = 1'b1;
        tick();
        start = 1'b0;
        e = mk(3'd1, 4'd0, 4'b1010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL timeout_restart obs=%h exp=%h", obs, e); end
    endtask

    // Continues from the FETCH entered at the end of test_timeout.
    task automatic test_ack_at_timeout();
        logic [10:0] e;
        for (int i = 1; i < 12; i++) begin
            tick();
            e = mk(3'd1, 4'(i), 4'b1010);
            vectors++; if (obs !== e) begin miscmp++; $display("FAIL ackto_wait%0d obs=%h exp=%h", i, obs, e); end
        end
        tick();
        e = mk(3'd1, 4'd12, 4'b1010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL ackto_limit obs=%h exp=%h", obs, e); end
        mif.mem_ack = 1'b1;
        #1;
        vectors++; if (strb !== 5'b11000) begin miscmp++; $display("FAIL ackto_strb strb=%b exp=11000", strb); end
        tick();
        e = mk(3'd2, 4'd0, 4'b0010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL ackto_decode obs=%h exp=%h", obs, e); end
        opcode = 2'b10; cmp = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        e = mk(3'd5, 4'd0, 4'b0000);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL ackto_halt obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_stop_add();
        logic [10:0] e;
        start = 1'b1; opcode = 2'b01; mif.mem_ack = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mif.mem_ack = 1'b0;
        tick();
        e = mk(3'd3, 4'd0, 4'b1010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL add_exec0 obs=%h exp=%h", obs, e); end
        opcode = 2'b00;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        e = mk(3'd3, 4'd1, 4'b1010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL add_exec1 obs=%h exp=%h", obs, e); end
        tick();
        mif.mem_ack = 1'b1;
        #1;
        vectors++; if (strb !== 5'b00011) begin miscmp++; $display("FAIL add_strb strb=%b exp=00011", strb); end
        tick();
        e = mk(3'd5, 4'd0, 4'b0000);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL add_halt obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_reset_mid_exec();
        logic [10:0] e;
        start = 1'b1; opcode = 2'b00; mif.mem_ack = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mif.mem_ack = 1'b0;
        repeat (6) tick();
        e = mk(3'd3, 4'd5, 4'b1010);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL rstexec_pre obs=%h exp=%h", obs, e); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mif.mem_ack = 1'b1;
        #1;
        e = mk(3'd0, 4'd0, 4'b0000);
        vectors++; if (obs !== e) begin miscmp++; $display("FAIL rstexec_post obs=%h exp=%h", obs, e); end
        vectors++; if (strb !== 5'b00000) begin miscmp++; $display("FAIL rstexec_strb strb=%b exp=00000", strb); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; cmp = 1'b1; mif.mem_ack = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            opcode = b2b_op[i];
            if (i == 10) stop = 1'b1;
            #1;
            vectors++;
            if ({state, count} !== {b2b_st[i], 4'd0}) begin
                miscmp++;
                $display("FAIL b2b_state%0d got=%0d/%0d exp=%0d/0", i, state, count, b2b_st[i]);
            end
            vectors++;
            if (strb !== b2b_sb[i]) begin
                miscmp++;
                $display("FAIL b2b_strb%0d strb=%b exp=%b", i, strb, b2b_sb[i]);
            end
            tick();
        end
        stop = 1'b0;
        vectors++; if (state !== 3'd5) begin miscmp++; $display("FAIL b2b_halt state=%0d exp=5", state); end
    endtask

    initial begin
        test_reset();
        test_load_loop();
        test_jmpc();
        test_store_wait();
        test_timeout();
        test_ack_at_timeout();
        test_stop_add();
        test_reset_mid_exec();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
